// File: rtl/tick_interval_meter.sv
// ---------------------------------------------------------------------------
// tick_interval_meter: measures clock cycles between accepted tick rising edges
// and flags a stall when no edge arrives within TIMEOUT cycles.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tick_interval_meter #(
  parameter int unsigned           WIDTH   = 28,
  parameter logic [WIDTH-1:0]      TIMEOUT = 28'd50_000_000
) (
  input  logic             clock_50,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clear,
  input  logic             tick_in,
  output logic [WIDTH-1:0] interval,
  output logic             interval_valid,
  output logic             measure_done,
  output logic             stalled,
  output logic [15:0]      edge_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_STALLED = 2'd2
  } state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic [WIDTH-1:0] interval_q, interval_d;
  logic             valid_q,    valid_d;
  logic             done_q,     done_d;
  logic             stalled_q,  stalled_d;
  logic [15:0]      edges_q,    edges_d;
  logic             tick_q;
  logic             rise;

  // tick_q is zero out of reset, so a tick already high at release is a rise.
  assign rise = tick_in & ~tick_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    interval_d = interval_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    stalled_d  = stalled_q;
    edges_d    = edges_q;

    if (clear) begin
      state_d    = S_IDLE;
      count_d    = '0;
      interval_d = '0;
      valid_d    = 1'b0;
      stalled_d  = 1'b0;
      edges_d    = '0;
    end else if (en) begin
      if (rise) begin
        edges_d = edges_q + 16'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_d = S_ARMED;
            count_d = WIDTH'(1);
          end
        end
        S_ARMED: begin
          // A rise coincident with count==TIMEOUT publishes rather than stalls.
          if (rise) begin
            interval_d = count_q;
            valid_d    = 1'b1;
            done_d     = 1'b1;
            count_d    = WIDTH'(1);
          end else if (count_q == TIMEOUT) begin
            state_d   = S_STALLED;
            stalled_d = 1'b1;
            valid_d   = 1'b0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
        S_STALLED: begin
          if (rise) begin
            state_d   = S_ARMED;
            stalled_d = 1'b0;
            count_d   = WIDTH'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      interval_q <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      stalled_q  <= 1'b0;
      edges_q    <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      interval_q <= interval_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      stalled_q  <= stalled_d;
      edges_q    <= edges_d;
      tick_q     <= tick_in;
    end
  end

  assign interval       = interval_q;
  assign interval_valid = valid_q;
  assign measure_done   = done_q;
  assign stalled        = stalled_q;
  assign edge_count     = edges_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_interval_meter.sv
// ---------------------------------------------------------------------------
// tb_tick_interval_meter: table-driven directed bench, TIMEOUT=100.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tick_interval_meter;

  localparam int unsigned WIDTH = 28;

  logic             clock_50;
  logic             reset_n;
  logic             en;
  logic             clear;
  logic             tick_in;
  logic [WIDTH-1:0] interval;
  logic             interval_valid;
  logic             measure_done;
  logic             stalled;
  logic [15:0]      edge_count;

  tick_interval_meter #(
    .WIDTH   (WIDTH),
    .TIMEOUT (28'd100)
  ) dut (
    .clock_50       (clock_50),
    .reset_n        (reset_n),
    .en             (en),
    .clear          (clear),
    .tick_in        (tick_in),
    .interval       (interval),
    .interval_valid (interval_valid),
    .measure_done   (measure_done),
    .stalled        (stalled),
    .edge_count     (edge_count)
  );

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  typedef struct {
    int               sc;
    int               cyc;
    logic [WIDTH-1:0] iv;
    logic             vld;
    logic             dn;
    logic             st;
    logic [15:0]      ec;
  } vec_t;

  vec_t vecs[$];
  int   n_applied;
  int   n_miss;

  task automatic add(input int sc, input int cyc, input int iv, input logic vld,
                     input logic dn, input logic st, input int ec);
    vec_t v;
    v.sc  = sc;
    v.cyc = cyc;
    v.iv  = WIDTH'(iv);
    v.vld = vld;
    v.dn  = dn;
    v.st  = st;
    v.ec  = 16'(ec);
    vecs.push_back(v);
  endtask

  task automatic compare(input string name, input vec_t v);
    n_applied++;
    if (interval !== v.iv || interval_valid !== v.vld || measure_done !== v.dn ||
        stalled !== v.st || edge_count !== v.ec) begin
      n_miss++;
      $display("FAIL %s: got iv=%0d vld=%b dn=%b st=%b ec=%0d, want iv=%0d vld=%b dn=%b st=%b ec=%0d",
               name, interval, interval_valid, measure_done, stalled, edge_count,
               v.iv, v.vld, v.dn, v.st, v.ec);
    end
  endtask

  function automatic logic f_tick(input int s, input int n);
    case (s)
      0:       return (n == 10) || (n == 35) || (n == 60);
      1:       return (n >= 10 && n <= 49) || (n == 80);
      2:       return (n == 5) || (n == 150) || (n == 170);
      3:       return (n == 10) || (n == 25) || (n == 40);
      4:       return (n == 10) || (n == 110);
      5:       return (n == 10) || (n == 30) || (n == 50) || (n == 60) || (n == 72);
      6:       return (n == 3) || (n == 9);
      7:       return (n <= 2) || (n == 7);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic f_en(input int s, input int n);
    return !(s == 3 && n >= 20 && n <= 29);
  endfunction

  function automatic logic f_clr(input int s, input int n);
    return (s == 5 && n == 50);
  endfunction

  task automatic reset_dut;
    reset_n = 1'b0;
    tick_in = 1'b0;
    en      = 1'b1;
    clear   = 1'b0;
    repeat (2) @(posedge clock_50);
    #1 reset_n = 1'b1;
  endtask

  // Cycle n: inputs driven and outputs sampled 1 time unit after edge n-1.
  task automatic run_scen(input int s, input int ncyc, input bit do_reset);
    if (do_reset) reset_dut();
    for (int n = 0; n <= ncyc; n++) begin
      tick_in = f_tick(s, n);
      en      = f_en(s, n);
      clear   = f_clr(s, n);
      foreach (vecs[i]) begin
        if (vecs[i].sc == s && vecs[i].cyc == n)
          compare($sformatf("s%0d_c%0d", s, n), vecs[i]);
      end
      @(posedge clock_50);
      #1;
    end
    tick_in = 1'b0;
    en      = 1'b1;
    clear   = 1'b0;
  endtask

  initial begin
    vec_t zero;
    n_applied = 0;
    n_miss    = 0;
    zero.sc = 0; zero.cyc = 0; zero.iv = '0; zero.vld = 0;
    zero.dn = 0; zero.st = 0; zero.ec = '0;

    // sc cyc iv vld dn st ec
    add(0,   0,   0, 0, 0, 0, 0);
    add(0,  11,   0, 0, 0, 0, 1);
    add(0,  35,   0, 0, 0, 0, 1);
    add(0,  36,  25, 1, 1, 0, 2);
    add(0,  37,  25, 1, 0, 0, 2);
    add(0,  61,  25, 1, 1, 0, 3);
    add(0,  62,  25, 1, 0, 0, 3);
    add(0, 160,  25, 1, 0, 0, 3);
    add(0, 161,  25, 0, 0, 1, 3);
    add(1,  50,   0, 0, 0, 0, 1);
    add(1,  81,  70, 1, 1, 0, 2);
    add(1,  82,  70, 1, 0, 0, 2);
    add(2, 105,   0, 0, 0, 0, 1);
    add(2, 106,   0, 0, 0, 1, 1);
    add(2, 151,   0, 0, 0, 0, 2);
    add(2, 171,  20, 1, 1, 0, 3);
    add(3,  41,  20, 1, 1, 0, 2);
    add(4, 110,   0, 0, 0, 0, 1);
    add(4, 111, 100, 1, 1, 0, 2);
    add(4, 112, 100, 1, 0, 0, 2);
    add(5,  31,  20, 1, 1, 0, 2);
    add(5,  51,   0, 0, 0, 0, 0);
    add(5,  61,   0, 0, 0, 0, 1);
    add(5,  73,  12, 1, 1, 0, 2);
    add(5,  79,  12, 1, 0, 0, 2);
    add(6,   4,   0, 0, 0, 0, 1);
    add(6,  10,   6, 1, 1, 0, 2);
    add(7,   1,   0, 0, 0, 0, 1);
    add(7,   8,   7, 1, 1, 0, 2);

    run_scen(0, 165, 1'b1);
    run_scen(1,  85, 1'b1);
    run_scen(2, 175, 1'b1);
    run_scen(3,  45, 1'b1);
    run_scen(4, 115, 1'b1);
    run_scen(5,  79, 1'b1);

    // Asynchronous reset mid-measurement: outputs clear before any clock edge.
    #2 reset_n = 1'b0;
    #1 compare("async_reset", zero);
    @(posedge clock_50);
    #1 reset_n = 1'b1;
    run_scen(6, 10, 1'b0);

    run_scen(7, 10, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tick_interval_meter.md
Name: tick_interval_meter

Overview:
- Inverse of the rate divider: a rate divider turns a cycle interval into a periodic tick; this block takes a tick stream and reports the clock-cycle interval between consecutive rising edges.
- Verifies divider outputs and game-timing ticks (movement, animation) at runtime; feeds debug HEX display and tick-health logic.
- Reports loss of ticks as a stall condition.

Parameters:
- WIDTH, 28, width of interval counter and result (matches divider interval width).
- TIMEOUT, 28'd50_000_000, cycles without an edge before declaring stall; must be >= 2 and <= 2^WIDTH-1.

Ports:
- clock_50  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable; 0 freezes counter/state and ignores edges.
- clear  input  1  synchronous restart, highest priority after reset_n.
- tick_in  input  1  tick stream, same clock domain, pulse or level.
- interval  output  WIDTH  last published interval in cycles.
- interval_valid  output  1  interval holds a real measurement.
- measure_done  output  1  one-cycle pulse when interval updates.
- stalled  output  1  TIMEOUT elapsed with no edge.
- edge_count  output  16  accepted rising edges, wraps at 16 bits.

Behaviour:
- Reset (reset_n=0, async): state=IDLE, count=0, tick_d=0, interval=0, interval_valid=0, measure_done=0, stalled=0, edge_count=0.
- tick_d <= tick_in every cycle, regardless of en and clear.
- rise = tick_in & ~tick_d (combinational). tick_in high on first cycle after reset release counts as a rise.
- A rise is accepted only when en=1 and clear=0.
- Accepted rise: edge_count+1 (wrap 16'hFFFF->0); count<=1.
- Interval definition: accepted edges in cycles t0 and t1 give interval t1-t0 (en=1 throughout).
- States:
  - IDLE: count held at 0. Accepted rise -> ARMED, no publish.
  - ARMED: accepted rise -> interval<=count, interval_valid<=1, measure_done=1 next cycle, stay ARMED.
  - ARMED, en=1, no rise, count==TIMEOUT -> STALLED: stalled<=1, interval_valid<=0, interval holds last value.
  - ARMED, en=1, otherwise: count<=count+1.
  - STALLED: count frozen. Accepted rise -> ARMED, stalled<=0, count<=1, no publish (interval unknown).
- Latency: measure_done and the new interval are visible in cycle t1+1. measure_done is high exactly one cycle.
- Rise in the same cycle as count==TIMEOUT: rise wins; interval=TIMEOUT is published; no stall. Max publishable interval is TIMEOUT, so count never overflows WIDTH.
- en=0: count, state, interval and flags held; measure_done=0; edges lost (no edge_count increment).
- Interval definition with en=0 gaps: interval counts only enabled cycles.
- clear=1: next state IDLE, count=0, interval=0, interval_valid=0, stalled=0, edge_count=0, measure_done=0. Overrides a simultaneous rise and timeout.
- reset_n asserted mid-measurement: immediate return to reset values. The first rise afterward re-arms only; it does not publish.

Test Plan (TIMEOUT=100, en=1 unless stated, cycle 0 = first cycle after reset release, tick_in low otherwise):
- 1-cycle pulses at cycles 10, 35, 60:
  - measure_done pulses at 36 and 61, interval=25 both times.
  - interval_valid 0 until 36, then 1.
  - edge_count=3 at 61.
- tick_in high cycles 10-49, then low, pulse at 80:
  - edge_count=2.
  - one measure_done at 81 with interval=70.
- Stall recovery:
  - Pulse at 5, then nothing -> stalled=1 and interval_valid=0 from cycle 106.
  - Pulse at 150 -> stalled=0, no measure_done.
  - Pulse at 170 -> interval=20 at 171.
- en gating:
  - Pulses at 10 and 40; en=0 cycles 20-29; extra pulse at 25 -> interval=20 at 41, edge_count=2.
  - Same bench, pulses at 10 and 110 with en=1 throughout -> interval=100 at 111, stalled stays 0.
- Clear and reset:
  - Pulses at 10 and 30 (interval=20).
  - clear=1 with a pulse at 50 -> all outputs zero, state IDLE.
  - Pulse at 60 re-arms; pulse at 72 -> interval=12.
  - reset_n low at cycle 80 mid-count -> outputs zero that cycle, without waiting for a clock edge.
